// File: rtl/xhci_mem_write_engine_if.sv
// Memory-write request interface between internal requesters and the xHCI write engine,
// together with the engine state type reported back over it.

package xhci_mwr_pkg;
    typedef enum logic [2:0] {
        WR_IDLE      = 3'd0,
        WR_DATA_INIT = 3'd1,
        WR_DATA      = 3'd2,
        WR_SEND      = 3'd3,
        WR_COMPLETE  = 3'd4
    } wr_state_e;
endpackage

interface IfMemoryWrite;
    import xhci_mwr_pkg::*;

    logic [63:0]  address;
    logic [31:0]  data_length;
    logic         has_data;
    logic [127:0] din;
    logic         wr_en;
    logic         wr_done;
    wr_state_e    state;

    modport sink   (input address, data_length, has_data, din, wr_en, wr_done, output state);
    modport source (output address, data_length, has_data, din, wr_en, wr_done, input state);
endinterface

// File: rtl/xhci_mem_write_engine.sv
// xHCI memory-write engine: buffers one request's 128-bit beats, then streams them as a packet.
// Define XHCI_MWR_4K_SPLIT_EN to split requests that cross a 4 KB boundary into two packets.

module xhci_mem_write_engine
    import xhci_mwr_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    IfMemoryWrite.sink    write_in,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          tx_sop,
    output logic          tx_eop,
    output logic [63:0]   tx_addr,
    output logic [12:0]   tx_len,
    output logic [127:0]  tx_data,
    output logic          err
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [32:0] MAX_LEN = 33'(FIFO_DEPTH * 16);

    wr_state_e state, state_nxt;

    logic [63:0]      req_addr;
    logic [31:0]      req_len;
    logic [127:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_after, total_beats, beat_idx;

    logic len_bad, misalign_in, req_cross;
    logic [12:0]      first_len;
    logic [CNT_W-1:0] first_beats;
    logic push_req, push, overflow, pop, short_data, last_beat, flush, err_set;
    logic second_pkt;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign len_bad = (write_in.data_length == 32'd0) ||
                     ({1'b0, write_in.data_length} > MAX_LEN);

`ifdef XHCI_MWR_4K_SPLIT_EN
    // Split point is the first 4 KB boundary after the start; an aligned start keeps it beat-aligned.
    assign misalign_in = ((33'(write_in.address[11:0]) + 33'(write_in.data_length)) > 33'h1000) &&
                         (write_in.address[3:0] != 4'd0);
    assign req_cross   = (33'(req_addr[11:0]) + 33'(req_len)) > 33'h1000;
    assign first_len   = 13'h1000 - 13'(req_addr[11:0]);
    assign first_beats = CNT_W'(first_len >> 4);
`else
    assign misalign_in = 1'b0;
    assign req_cross   = 1'b0;
    assign first_len   = '0;
    assign first_beats = '0;
`endif

    // Length is bounded by the FIFO size once accepted, so the beat count always fits.
    assign total_beats = CNT_W'(req_len[31:4]) + CNT_W'(|req_len[3:0]);

    assign push_req    = ((state == WR_DATA_INIT) || (state == WR_DATA)) && write_in.wr_en;
    assign push        = push_req && (count != CNT_W'(FIFO_DEPTH));
    assign overflow    = push_req && (count == CNT_W'(FIFO_DEPTH));
    assign pop         = (state == WR_SEND) && tx_ready;
    assign count_after = count + CNT_W'(push);
    assign short_data  = count_after < total_beats;
    assign last_beat   = beat_idx == (total_beats - 1'b1);
    assign flush       = (state == WR_COMPLETE) && !write_in.has_data;

    assign err_set = ((state == WR_IDLE) && write_in.has_data && (len_bad || misalign_in)) ||
                     overflow ||
                     ((state == WR_DATA) && write_in.wr_done && short_data);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= WR_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        unique case (state)
            WR_IDLE: begin
                if (write_in.has_data)
                    state_nxt = (len_bad || misalign_in) ? WR_COMPLETE : WR_DATA_INIT;
            end
            WR_DATA_INIT: state_nxt = WR_DATA;
            WR_DATA: begin
                if (write_in.wr_done)
                    state_nxt = short_data ? WR_COMPLETE : WR_SEND;
            end
            WR_SEND: begin
                if (tx_ready && last_beat) state_nxt = WR_COMPLETE;
            end
            WR_COMPLETE: begin
                if (!write_in.has_data) state_nxt = WR_IDLE;
            end
            default: state_nxt = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_addr <= '0;
            req_len  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            beat_idx <= '0;
            err      <= 1'b0;
        end else begin
            if ((state == WR_IDLE) && write_in.has_data) begin
                req_addr <= write_in.address;
                req_len  <= write_in.data_length;
            end
            // Surplus beats left behind after a send are dropped here.
            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                beat_idx <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= next_ptr(wr_ptr);
                    count  <= count + 1'b1;
                end
                if (pop) begin
                    rd_ptr   <= next_ptr(rd_ptr);
                    count    <= count - 1'b1;
                    beat_idx <= beat_idx + 1'b1;
                end
            end
            if (flush)        err <= 1'b0;
            else if (err_set) err <= 1'b1;
        end
    end

    // NOTE: the data array has no reset; emptiness is tracked by the reset pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= write_in.din;
    end

    assign second_pkt = req_cross && (beat_idx >= first_beats);

    assign tx_valid = (state == WR_SEND);
    assign tx_sop   = tx_valid && ((beat_idx == '0) || (req_cross && (beat_idx == first_beats)));
    assign tx_eop   = tx_valid && (last_beat || (req_cross && (beat_idx == (first_beats - 1'b1))));
    assign tx_addr  = !tx_valid ? '0 :
                      second_pkt ? {req_addr[63:12] + 52'd1, 12'h000} : req_addr;
    assign tx_len   = !tx_valid ? '0 :
                      second_pkt ? (13'(req_len) - first_len) :
                      req_cross  ? first_len : 13'(req_len);
    assign tx_data  = tx_valid ? mem[rd_ptr] : '0;

    assign write_in.state = state;

endmodule

// File: tb/tb_xhci_mem_write_engine.sv
// Directed self-checking bench for xhci_mem_write_engine.

module tb_xhci_mem_write_engine;
    import xhci_mwr_pkg::*;

    localparam int FIFO_DEPTH = 16;

    logic         clk;
    logic         rst;
    logic         tx_valid, tx_ready, tx_sop, tx_eop, err;
    logic [63:0]  tx_addr;
    logic [12:0]  tx_len;
    logic [127:0] tx_data;

    IfMemoryWrite mw();

    xhci_mem_write_engine #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .write_in (mw),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_sop   (tx_sop),
        .tx_eop   (tx_eop),
        .tx_addr  (tx_addr),
        .tx_len   (tx_len),
        .tx_data  (tx_data),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [127:0] got_data [64];
    logic         got_sop  [64];
    logic         got_eop  [64];
    logic [63:0]  got_addr [64];
    logic [12:0]  got_len  [64];
    int           n_beats;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] beat_val(input int t, input int k);
        return {32'(t), 32'(k), 32'hC0DE_0000 | 32'(k), ~32'(t * 64 + k)};
    endfunction

    // Drains WR_SEND, recording accepted beats and checking stability across stalls.
    task automatic collect(input bit toggle);
        int  cyc;
        bit  stalled;
        logic [127:0] prev;
        n_beats = 0;
        stalled = 0;
        prev    = '0;
        cyc     = 0;
        while (mw.state == WR_SEND && cyc < 200) begin
            tx_ready = toggle ? cyc[0] : 1'b1;
            #1;
            if (stalled) begin
                check("stall_valid", tx_valid, 1'b1);
                check("stall_data", tx_data, prev);
            end
            if (tx_valid && tx_ready && n_beats < 64) begin
                got_data[n_beats] = tx_data;
                got_sop[n_beats]  = tx_sop;
                got_eop[n_beats]  = tx_eop;
                got_addr[n_beats] = tx_addr;
                got_len[n_beats]  = tx_len;
                n_beats++;
            end
            stalled = tx_valid && !tx_ready;
            prev    = tx_data;
            step();
            cyc++;
        end
        if (cyc >= 200) check("send_timeout", 1'b1, 1'b0);
        tx_ready = 1'b0;
    endtask

    task automatic run_req(input int t, input logic [63:0] addr, input logic [31:0] len,
                           input int n_push, input bit done_with_last, input bit toggle,
                           input bit do_collect);
        mw.address     = addr;
        mw.data_length = len;
        mw.has_data    = 1'b1;
        step();
        check($sformatf("t%0d_init", t), mw.state, WR_DATA_INIT);
        // Later changes must not affect the captured request.
        mw.address     = 64'hDEAD_BEEF_0000_0F00;
        mw.data_length = 32'h999;
        for (int k = 0; k < n_push; k++) begin
            mw.wr_en   = 1'b1;
            mw.din     = beat_val(t, k);
            mw.wr_done = done_with_last && (k == n_push - 1);
            step();
        end
        mw.wr_en = 1'b0;
        if (!done_with_last) begin
            mw.wr_done = 1'b1;
            step();
        end
        mw.wr_done = 1'b0;
        if (do_collect) collect(toggle);
    endtask

    task automatic finish_req(input int t);
        mw.has_data = 1'b0;
        step();
        check($sformatf("t%0d_idle", t), mw.state, WR_IDLE);
        check($sformatf("t%0d_err_clr", t), err, 1'b0);
    endtask

    task automatic check_beats(input int t, input int n, input logic [63:0] addr,
                               input logic [12:0] len);
        check($sformatf("t%0d_nbeats", t), n_beats, n);
        for (int k = 0; k < n && k < n_beats; k++) begin
            check($sformatf("t%0d_data%0d", t, k), got_data[k], beat_val(t, k));
            check($sformatf("t%0d_sop%0d", t, k), got_sop[k], k == 0);
            check($sformatf("t%0d_eop%0d", t, k), got_eop[k], k == n - 1);
        end
        if (n_beats > 0) begin
            check($sformatf("t%0d_addr", t), got_addr[0], addr);
            check($sformatf("t%0d_len", t), got_len[0], len);
        end
        check($sformatf("t%0d_done", t), mw.state, WR_COMPLETE);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, mw.state, WR_IDLE);
        check({tag, "_valid"}, tx_valid, 1'b0);
        check({tag, "_sop"}, tx_sop, 1'b0);
        check({tag, "_eop"}, tx_eop, 1'b0);
        check({tag, "_addr"}, tx_addr, 64'd0);
        check({tag, "_len"}, tx_len, 13'd0);
        check({tag, "_data"}, tx_data, 128'd0);
        check({tag, "_err"}, err, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst            = 1'b0;
        tx_ready       = 1'b0;
        mw.address     = '0;
        mw.data_length = '0;
        mw.has_data    = 1'b0;
        mw.din         = '0;
        mw.wr_en       = 1'b0;
        mw.wr_done     = 1'b0;
        step();
        step();
        check_reset_outputs("reset");
        rst = 1'b1;
        step();

        // Basic two-beat request.
        run_req(1, 64'h1000, 32'h20, 2, 1'b0, 1'b0, 1'b1);
        check_beats(1, 2, 64'h1000, 13'd32);
        check("t1_err", err, 1'b0);

        // COMPLETE holds while has_data stays high.
        step();
        step();
        check("t1_hold", mw.state, WR_COMPLETE);
        finish_req(1);

        // Four beats under alternating backpressure; last push coincides with wr_done.
        run_req(2, 64'h2000, 32'h40, 4, 1'b1, 1'b1, 1'b1);
        check_beats(2, 4, 64'h2000, 13'd64);
        finish_req(2);

        // Partial last beat with a surplus pushed beat that must be discarded.
        run_req(3, 64'h3000, 32'h24, 4, 1'b0, 1'b0, 1'b1);
        check_beats(3, 3, 64'h3000, 13'd36);
        finish_req(3);

        // Zero length is rejected without emitting anything.
        mw.address = 64'h4000; mw.data_length = 32'd0; mw.has_data = 1'b1;
        step();
        check("zero_state", mw.state, WR_COMPLETE);
        check("zero_err", err, 1'b1);
        check("zero_valid", tx_valid, 1'b0);
        finish_req(4);

        // One byte beyond FIFO capacity is rejected.
        mw.address = 64'h4000; mw.data_length = 32'(FIFO_DEPTH * 16 + 1); mw.has_data = 1'b1;
        step();
        check("big_state", mw.state, WR_COMPLETE);
        check("big_err", err, 1'b1);
        check("big_valid", tx_valid, 1'b0);
        finish_req(5);

        // Exactly FIFO capacity is accepted and fully sent.
        run_req(6, 64'h5000, 32'(FIFO_DEPTH * 16), FIFO_DEPTH, 1'b0, 1'b0, 1'b1);
        check_beats(6, FIFO_DEPTH, 64'h5000, 13'(FIFO_DEPTH * 16));
        check("t6_err", err, 1'b0);
        finish_req(6);

        // Pushing into a full FIFO drops the beat and sets a sticky error.
        run_req(7, 64'h6000, 32'h10, FIFO_DEPTH + 1, 1'b0, 1'b0, 1'b1);
        check_beats(7, 1, 64'h6000, 13'd16);
        check("t7_err", err, 1'b1);
        finish_req(7);

        // Too few beats at wr_done: error, nothing sent.
        run_req(8, 64'h7000, 32'h30, 2, 1'b0, 1'b0, 1'b0);
        check("short_state", mw.state, WR_COMPLETE);
        check("short_err", err, 1'b1);
        check("short_valid", tx_valid, 1'b0);
        finish_req(8);

        // Reset in the middle of a send after one accepted beat.
        run_req(9, 64'h8000, 32'h30, 3, 1'b0, 1'b0, 1'b0);
        check("t9_send", mw.state, WR_SEND);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        check("t9_beat1", tx_data, beat_val(9, 1));
        rst         = 1'b0;
        mw.has_data = 1'b0;
        #1;
        check_reset_outputs("midrst");
        step();
        rst = 1'b1;
        tx_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("postrst_valid%0d", k), tx_valid, 1'b0);
        end
        tx_ready = 1'b0;
        run_req(10, 64'h9000, 32'h20, 2, 1'b0, 1'b0, 1'b1);
        check_beats(10, 2, 64'h9000, 13'd32);
        finish_req(10);

`ifdef XHCI_MWR_4K_SPLIT_EN
        // Crossing request becomes two one-beat packets.
        run_req(11, 64'h1FF0, 32'h20, 2, 1'b0, 1'b0, 1'b1);
        check("split_nbeats", n_beats, 2);
        check("split_d0", got_data[0], beat_val(11, 0));
        check("split_d1", got_data[1], beat_val(11, 1));
        check("split_sop0", got_sop[0], 1'b1);
        check("split_eop0", got_eop[0], 1'b1);
        check("split_addr0", got_addr[0], 64'h1FF0);
        check("split_len0", got_len[0], 13'd16);
        check("split_sop1", got_sop[1], 1'b1);
        check("split_eop1", got_eop[1], 1'b1);
        check("split_addr1", got_addr[1], 64'h2000);
        check("split_len1", got_len[1], 13'd16);
        finish_req(11);

        // Misaligned crossing request is rejected.
        mw.address = 64'h1FF8; mw.data_length = 32'h20; mw.has_data = 1'b1;
        step();
        check("misalign_state", mw.state, WR_COMPLETE);
        check("misalign_err", err, 1'b1);
        check("misalign_valid", tx_valid, 1'b0);
        finish_req(12);
`else
        // Without splitting, a crossing request is a single packet.
        run_req(11, 64'h1FF0, 32'h20, 2, 1'b0, 1'b0, 1'b1);
        check_beats(11, 2, 64'h1FF0, 13'd32);
        finish_req(11);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
